// File: rtl/rdma_remap_pkg.sv
// Shared types and defaults for the rdma_remap address engine and its requester scheduler.
package rdma_remap_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam logic [31:0] REMAP_OFFSET = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_CALC = 2'd1,
        ENG_WAIT = 2'd2
    } eng_state_e;

endpackage

// File: rtl/rdma_remap.sv
// Address remap engine: result = local + OFFSET (mod 2^32), one-cycle ready pulse per start.
module rdma_remap
    import rdma_remap_pkg::*;
#(
    parameter logic [31:0] OFFSET = REMAP_OFFSET
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] local_addr_i,
    output logic [31:0] remote_addr_o,
    output logic        ready_o
);

    eng_state_e  state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        ready_q, ready_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ENG_IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // WAIT holds off a new job until start drops, so a held start is never served twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ENG_IDLE: if (start_i) state_d = ENG_CALC;
            ENG_CALC: state_d = ENG_WAIT;
            ENG_WAIT: if (!start_i) state_d = ENG_IDLE;
            default:  state_d = ENG_IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        ready_d  = 1'b0;
        case (state_q)
            ENG_IDLE: if (start_i) result_d = local_addr_i + OFFSET;
            ENG_CALC: ready_d = 1'b1;
            default:  ready_d = 1'b0;
        endcase
    end

    assign remote_addr_o = result_q;
    assign ready_o       = ready_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr_i+1, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        // The last-served requester (ptr_i) is visited last, so it has lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/rdma_remap_sched.sv
// Round-robin scheduler sharing one rdma_remap engine among NUM_REQ requesters.
// Optional engine-response watchdog enabled by defining RDMA_SCHED_TIMEOUT_EN.
module rdma_remap_sched
    import rdma_remap_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [ADDR_W-1:0]         rsp_addr,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      eng_start,
    output logic [ADDR_W-1:0]         eng_local_addr,
    input  logic [ADDR_W-1:0]         eng_remote_addr,
    input  logic                      eng_ready,
    output sched_state_e              dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: req_valid is held by the requester until a one-cycle req_ready pulse;
    // exactly one rsp_valid pulse follows per accepted request, and only one is in flight.

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
    logic               rsp_err_q, rsp_err_d;
    logic               eng_start_q, eng_start_d;
    logic [ADDR_W-1:0]  eng_local_addr_q, eng_local_addr_d;
    logic               timeout_hit;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [ADDR_W-1:0]  req_addr_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

`ifdef RDMA_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_comb begin
        tmr_d = tmr_q;
        if (state_q == ST_IDLE) tmr_d = '0;
        else if (state_q == ST_BUSY) tmr_d = tmr_q + TMR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tmr_q <= '0;
        else        tmr_q <= tmr_d;
    end

    // A response arriving on the limit cycle still wins over the timeout.
    assign timeout_hit = (state_q == ST_BUSY) && (tmr_q == TMR_W'(TIMEOUT_CYCLES)) && !eng_ready;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            ptr_q            <= IDX_W'(NUM_REQ - 1);
            gnt_idx_q        <= '0;
            req_ready_q      <= '0;
            rsp_valid_q      <= '0;
            rsp_addr_q       <= '0;
            rsp_err_q        <= 1'b0;
            eng_start_q      <= 1'b0;
            eng_local_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            gnt_idx_q        <= gnt_idx_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_addr_q       <= rsp_addr_d;
            rsp_err_q        <= rsp_err_d;
            eng_start_q      <= eng_start_d;
            eng_local_addr_q <= eng_local_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_any) state_d = ST_BUSY;
            ST_BUSY:  if (eng_ready || timeout_hit) state_d = ST_DRAIN;
            ST_DRAIN: if (!eng_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d            = ptr_q;
        gnt_idx_d        = gnt_idx_q;
        req_ready_d      = '0;
        rsp_valid_d      = '0;
        rsp_addr_d       = rsp_addr_q;
        rsp_err_d        = rsp_err_q;
        eng_start_d      = 1'b0;
        eng_local_addr_d = eng_local_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready_d      = arb_grant;
                    gnt_idx_d        = arb_idx;
                    eng_local_addr_d = req_addr_a[arb_idx];
                end
            end
            ST_BUSY: begin
                if (eng_ready) begin
                    rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
                    rsp_addr_d  = eng_remote_addr;
                    rsp_err_d   = 1'b0;
                    ptr_d       = gnt_idx_q;
                end else if (timeout_hit) begin
                    rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
                    rsp_addr_d  = '0;
                    rsp_err_d   = 1'b1;
                    ptr_d       = gnt_idx_q;
                end else begin
                    eng_start_d = 1'b1;
                end
            end
            default: eng_start_d = 1'b0;
        endcase
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_addr       = rsp_addr_q;
    assign rsp_err        = rsp_err_q;
    assign busy           = (state_q != ST_IDLE);
    assign eng_start      = eng_start_q;
    assign eng_local_addr = eng_local_addr_q;
    assign dbg_state_o    = state_q;

endmodule
